// File: rtl/fsm_10111_sync_tx_if.sv
// Frame transmitter handshake and serial line bundle.
interface fsm_10111_sync_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              stuff;
  logic              done;

  modport master (
    output start, data_in,
    input  ready, tx_bit, tx_valid, stuff, done
  );

  modport slave (
    input  start, data_in,
    output ready, tx_bit, tx_valid, stuff, done
  );
endinterface

// File: rtl/fsm_10111_sync_tx.sv
// Serial frame transmitter: sync word, bit-stuffed payload, idle gap.
// Stuffing keeps the sync word from reappearing anywhere after the sync field.
module fsm_10111_sync_tx #(
  parameter int unsigned            PAT_LEN    = 5,
  parameter logic [PAT_LEN-1:0]     PATTERN    = PAT_LEN'(5'b10111),
  parameter int unsigned            DATA_W     = 8,
  parameter int unsigned            GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fsm_10111_sync_tx_if.slave      bus
);

  localparam int unsigned HIST_W  = PAT_LEN - 1;
  localparam int unsigned SHIFT_W = PAT_LEN + DATA_W;
  localparam int unsigned MAX_A   = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
  localparam int unsigned MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  // A stuff bit goes out whenever the history equals the sync word minus its last bit.
  localparam logic [HIST_W-1:0] STUFF_HIST = PATTERN[PAT_LEN-1:1];
  localparam logic              STUFF_BIT  = ~PATTERN[0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shreg_q, shreg_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic                ready_q, ready_d;
  logic                tx_bit_q, tx_bit_d;
  logic                tx_valid_q, tx_valid_d;
  logic                stuff_q, stuff_d;
  logic                done_q, done_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      hist_q     <= '0;
      ready_q    <= 1'b1;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      stuff_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      hist_q     <= hist_d;
      ready_q    <= ready_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      stuff_q    <= stuff_d;
      done_q     <= done_d;
    end
  end

  // Next state and the line values presented after the coming edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    hist_d     = hist_q;
    ready_d    = 1'b0;
    tx_bit_d   = 1'b0;
    tx_valid_d = 1'b0;
    stuff_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.start && ready_q) begin
          // Sync word and payload share one MSB-first shifter.
          ready_d = 1'b0;
          shreg_d = {PATTERN, bus.data_in};
          cnt_d   = '0;
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        tx_valid_d = 1'b1;
        tx_bit_d   = shreg_q[SHIFT_W-1];
        shreg_d    = {shreg_q[SHIFT_W-2:0], 1'b0};
        hist_d     = {hist_q[HIST_W-2:0], tx_bit_d};
        if (cnt_q == CNT_W'(PAT_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        tx_valid_d = 1'b1;
        if (hist_q == STUFF_HIST) begin
          // Payload bit is held; only the stuff bit goes out this slot.
          stuff_d  = 1'b1;
          tx_bit_d = STUFF_BIT;
        end else begin
          tx_bit_d = shreg_q[SHIFT_W-1];
          shreg_d  = {shreg_q[SHIFT_W-2:0], 1'b0};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        hist_d = {hist_q[HIST_W-2:0], tx_bit_d};
      end

      S_GAP: begin
        hist_d = {hist_q[HIST_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.ready    = ready_q;
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.stuff    = stuff_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fsm_10111_sync_tx.sv
// Self-checking bench for fsm_10111_sync_tx: directed frames, held start,
// mid-frame reset and random payloads against a list-based frame model.
module tb_fsm_10111_sync_tx;

  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst;

  fsm_10111_sync_tx_if #(.DATA_W(DATA_W)) bus ();

  fsm_10111_sync_tx #(
    .PAT_LEN    (5),
    .PATTERN    (5'b10111),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          cap_bits[$];
  bit          cap_stf[$];
  logic [31:0] cap_line;
  logic [31:0] cap_stuff;
  int          cap_done_at;
  int          cap_done_cnt;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line: sync word, then payload with a 0 inserted whenever the
  // last four line bits read 1011.
  function automatic void model(input logic [7:0] d, output int len,
                                output logic [31:0] line, output logic [31:0] stf);
    bit          q[$];
    bit          s[$];
    logic [4:0]  pat;
    int          n;
    pat = 5'b10111;
    for (int j = 4; j >= 0; j--) begin
      q.push_back(pat[j]);
      s.push_back(1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      n = q.size();
      if (q[n-4] == 1'b1 && q[n-3] == 1'b0 && q[n-2] == 1'b1 && q[n-1] == 1'b1) begin
        q.push_back(1'b0);
        s.push_back(1'b1);
      end
      q.push_back(d[i]);
      s.push_back(1'b0);
    end
    len  = q.size();
    line = '0;
    stf  = '0;
    for (int j = 0; j < q.size(); j++) begin
      line = {line[30:0], q[j]};
      stf  = {stf[30:0], s[j]};
    end
  endfunction

  // Collect valid line bits until done, bounded by a cycle budget.
  task automatic capture(input bit noisy);
    cap_bits.delete();
    cap_stf.delete();
    cap_line     = '0;
    cap_stuff    = '0;
    cap_done_at  = 0;
    cap_done_cnt = 0;
    for (int c = 0; c < 40 && cap_done_cnt == 0; c++) begin
      if (noisy) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.data_in = 8'($urandom);
      end
      step();
      if (bus.tx_valid === 1'b1) begin
        cap_bits.push_back(bus.tx_bit);
        cap_stf.push_back(bus.stuff);
        cap_line  = {cap_line[30:0], bus.tx_bit};
        cap_stuff = {cap_stuff[30:0], bus.stuff};
      end
      if (bus.done === 1'b1) begin
        cap_done_cnt++;
        cap_done_at = cap_bits.size();
      end
    end
    bus.start = 1'b0;
    check("frame_done_seen", 64'(cap_done_cnt), 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit noisy,
                           input int k_len, input logic [31:0] k_line,
                           input logic [31:0] k_stuff);
    int          m_len;
    logic [31:0] m_line;
    logic [31:0] m_stf;
    int          hits;
    int          hit_at;
    logic [4:0]  w;
    logic [7:0]  rec;
    int          gw;
    gw = 0;
    while (bus.ready !== 1'b1 && gw < 40) begin
      step();
      gw++;
    end
    check({tag, "_ready_before"}, 64'(bus.ready), 64'd1);
    bus.start   = 1'b1;
    bus.data_in = d;
    step();
    check({tag, "_accept"}, {bus.ready, bus.tx_valid}, 64'd0);
    if (!noisy) begin
      bus.start   = 1'b0;
      bus.data_in = ~d;
    end
    capture(noisy);
    model(d, m_len, m_line, m_stf);
    check({tag, "_len"},     64'(cap_bits.size()), 64'(m_len));
    check({tag, "_line"},    64'(cap_line), 64'(m_line));
    check({tag, "_stuff"},   64'(cap_stuff), 64'(m_stf));
    check({tag, "_done_at"}, 64'(cap_done_at), 64'(m_len));
    if (k_len != 0) begin
      check({tag, "_len_k"},   64'(cap_bits.size()), 64'(k_len));
      check({tag, "_line_k"},  64'(cap_line), 64'(k_line));
      check({tag, "_stuff_k"}, 64'(cap_stuff), 64'(k_stuff));
    end
    // Overlapping 10111 detector over the received line
    w      = '0;
    hits   = 0;
    hit_at = 0;
    rec    = '0;
    for (int j = 0; j < cap_bits.size(); j++) begin
      w = {w[3:0], cap_bits[j]};
      if (w == 5'b10111) begin
        hits++;
        if (hit_at == 0) hit_at = j + 1;
      end
      if (!cap_stf[j]) rec = {rec[6:0], cap_bits[j]};
    end
    check({tag, "_det_hits"}, 64'(hits), 64'd1);
    check({tag, "_det_pos"},  64'(hit_at), 64'd5);
    check({tag, "_payload"},  64'(rec), 64'(d));
    for (int g = 0; g < 2; g++) begin
      step();
      check({tag, "_gap"}, {bus.tx_valid, bus.tx_bit, bus.ready, bus.done}, 64'd0);
    end
    step();
    check({tag, "_ready_after"}, {bus.ready, bus.tx_valid}, 64'b10);
  endtask

  initial begin
    logic [39:0] got_v, got_b, got_d, got_r;
    logic [39:0] exp_v, exp_b, exp_d, exp_r;
    logic [4:0]  pat;
    int          o;
    int          gw;

    pat         = 5'b10111;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    step();
    step();
    check("reset_outputs", {bus.ready, bus.tx_bit, bus.tx_valid, bus.stuff, bus.done}, 64'b10000);
    rst = 1'b0;
    step();

    // Directed frames with known line images
    run_frame("t1_ff", 8'hFF, 1'b0, 13, 32'h17FF, 32'h0);
    run_frame("t2_b7", 8'hB7, 1'b0, 14, 32'h2F67, 32'h10);
    run_frame("t3_5d", 8'h5D, 1'b0, 14, 32'h2EB5, 32'h8);

    // start held high: frames back to back with a 17-cycle period
    bus.start   = 1'b1;
    bus.data_in = 8'h00;
    got_v = '0; got_b = '0; got_d = '0; got_r = '0;
    exp_v = '0; exp_b = '0; exp_d = '0; exp_r = '0;
    for (int s = 1; s <= 40; s++) begin
      step();
      got_v = {got_v[38:0], bus.tx_valid};
      got_b = {got_b[38:0], bus.tx_bit};
      got_d = {got_d[38:0], bus.done};
      got_r = {got_r[38:0], bus.ready};
      o     = (s - 1) % 17;
      exp_v = {exp_v[38:0], (o >= 1 && o <= 13)};
      exp_b = {exp_b[38:0], (o >= 1 && o <= 5) ? pat[3'(5 - o)] : 1'b0};
      exp_d = {exp_d[38:0], (o == 13)};
      exp_r = {exp_r[38:0], (o == 16)};
    end
    check("t4_valid", 64'(got_v), 64'(exp_v));
    check("t4_bits",  64'(got_b), 64'(exp_b));
    check("t4_done",  64'(got_d), 64'(exp_d));
    check("t4_ready", 64'(got_r), 64'(exp_r));
    bus.start = 1'b0;
    gw = 0;
    while (bus.ready !== 1'b1 && gw < 40) begin
      step();
      gw++;
    end
    check("t4_drain", 64'(bus.ready), 64'd1);

    // Reset on the third payload bit, together with start
    bus.start   = 1'b1;
    bus.data_in = 8'hFF;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("t5_mid_frame", {bus.tx_valid, bus.done}, 64'b10);
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    check("t5_abort", {bus.ready, bus.tx_valid, bus.done, bus.stuff}, 64'b1000);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    check("t5_idle", {bus.ready, bus.tx_valid, bus.done, bus.stuff}, 64'b1000);
    run_frame("t5_ff", 8'hFF, 1'b0, 13, 32'h17FF, 32'h0);

    // Random payloads with start/data_in noise while busy
    for (int f = 0; f < 200; f++) begin
      run_frame("rnd", 8'($urandom), 1'b1, 0, 32'h0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
